// File: rtl/ovi_issue_ctrl.sv
// OVI issue controller: buffers vector instructions and issues them
// against vector-unit credits and an in-flight limit, with halt/drain.
module ovi_issue_ctrl #(
  parameter int DEPTH        = 4,
  parameter int CREDITS      = 4,
  parameter int MAX_INFLIGHT = 8,
  parameter int INSTR_W      = 32,
  parameter int OPND_W       = 64,
  parameter int VL_W         = 14,
  parameter int SEW_W        = 3
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 HALT,
  input  logic                 REQ_VALID,
  output logic                 REQ_READY,
  input  logic [INSTR_W-1:0]   REQ_INSTR,
  input  logic [OPND_W-1:0]    REQ_OPND,
  input  logic                 CFG_WE,
  input  logic [VL_W-1:0]      CFG_VL,
  input  logic [SEW_W-1:0]     CFG_SEW,
  output logic                 ISSUE_VALID,
  output logic [INSTR_W-1:0]   ISSUE_INSTR,
  output logic [OPND_W-1:0]    ISSUE_OPND,
  output logic [VL_W-1:0]      ISSUE_VL,
  output logic [SEW_W-1:0]     ISSUE_SEW,
  input  logic                 ISSUE_CREDIT,
  input  logic                 COMPLETED_VALID,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] INFLIGHT,
  output logic                 IDLE,
  output logic                 ERR
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
  localparam int CW   = $clog2(CREDITS + 1);
  localparam int IW   = $clog2(MAX_INFLIGHT + 1);

  localparam logic [1:0] S_HALTED = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;

  logic [INSTR_W-1:0] q_instr [DEPTH];
  logic [OPND_W-1:0]  q_opnd  [DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [CNTW-1:0]    count, count_nxt;
  logic [CW-1:0]      credits, credits_nxt;
  logic [IW-1:0]      inflight, inflight_nxt;
  logic [1:0]         state, state_nxt;
  logic [VL_W-1:0]    vl;
  logic [SEW_W-1:0]   sew;

  logic push, issue, empty, full;
  logic credit_ok, credit_err, comp_ok, comp_err;

  assign full  = (count == CNTW'(DEPTH));
  assign empty = (count == '0);
  assign push  = REQ_VALID && REQ_READY;

  assign issue = (state == S_RUN) && !HALT && !empty
              && (credits != '0)
              && (inflight < IW'(MAX_INFLIGHT));

  // a concurrent issue absorbs a return that would otherwise overflow
  assign credit_ok  = ISSUE_CREDIT && (issue || credits != CW'(CREDITS));
  assign credit_err = ISSUE_CREDIT && !credit_ok;
  assign comp_ok    = COMPLETED_VALID && (issue || inflight != '0);
  assign comp_err   = COMPLETED_VALID && !comp_ok;

  always_comb begin
    count_nxt = count;
    unique case ({push, issue})
      2'b10:   count_nxt = count + CNTW'(1);
      2'b01:   count_nxt = count - CNTW'(1);
      default: count_nxt = count;
    endcase
  end

  always_comb begin
    credits_nxt = credits;
    unique case ({issue, credit_ok})
      2'b10:   credits_nxt = credits - CW'(1);
      2'b01:   credits_nxt = credits + CW'(1);
      default: credits_nxt = credits;
    endcase
  end

  always_comb begin
    inflight_nxt = inflight;
    unique case ({issue, comp_ok})
      2'b10:   inflight_nxt = inflight + IW'(1);
      2'b01:   inflight_nxt = inflight - IW'(1);
      default: inflight_nxt = inflight;
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_HALTED: if (!HALT) state_nxt = S_RUN;
      S_RUN:    if (HALT) state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (!HALT)                  state_nxt = S_RUN;
        else if (inflight_nxt == '0) state_nxt = S_HALTED;
      end
      default:  state_nxt = S_HALTED;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      credits  <= CW'(CREDITS);
      inflight <= '0;
      state    <= S_HALTED;
      vl       <= VL_W'(8);
      sew      <= SEW_W'(2);
      ERR      <= 1'b0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + AW'(1);
      if (issue) rd_ptr <= rd_ptr + AW'(1);
      count    <= count_nxt;
      credits  <= credits_nxt;
      inflight <= inflight_nxt;
      state    <= state_nxt;
      if (CFG_WE) begin
        vl  <= CFG_VL;
        sew <= CFG_SEW;
      end
      if (credit_err || comp_err) ERR <= 1'b1;
    end
  end

  // payload storage needs no reset; occupancy is tracked by count
  always_ff @(posedge CLK) begin
    if (push) begin
      q_instr[wr_ptr] <= REQ_INSTR;
      q_opnd[wr_ptr]  <= REQ_OPND;
    end
  end

  assign REQ_READY   = RST_N && !full;
  assign ISSUE_VALID = issue;
  assign ISSUE_INSTR = q_instr[rd_ptr];
  assign ISSUE_OPND  = q_opnd[rd_ptr];
  assign ISSUE_VL    = vl;
  assign ISSUE_SEW   = sew;
  assign INFLIGHT    = inflight;
  assign IDLE        = (state == S_HALTED);

endmodule

// File: tb/tb_ovi_issue_ctrl.sv
// Directed bench for ovi_issue_ctrl: issue, credits, full FIFO,
// halt/drain, config timing and sticky error.
module tb_ovi_issue_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N, HALT, REQ_VALID, REQ_READY;
  logic [31:0] REQ_INSTR;
  logic [63:0] REQ_OPND;
  logic        CFG_WE;
  logic [13:0] CFG_VL;
  logic [2:0]  CFG_SEW;
  logic        ISSUE_VALID;
  logic [31:0] ISSUE_INSTR;
  logic [63:0] ISSUE_OPND;
  logic [13:0] ISSUE_VL;
  logic [2:0]  ISSUE_SEW;
  logic        ISSUE_CREDIT, COMPLETED_VALID;
  logic [3:0]  INFLIGHT;
  logic        IDLE, ERR;

  int passed = 0;
  int total  = 0;

  always #5 CLK = ~CLK;

  ovi_issue_ctrl dut (
    .CLK(CLK), .RST_N(RST_N), .HALT(HALT),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_INSTR(REQ_INSTR), .REQ_OPND(REQ_OPND),
    .CFG_WE(CFG_WE), .CFG_VL(CFG_VL), .CFG_SEW(CFG_SEW),
    .ISSUE_VALID(ISSUE_VALID), .ISSUE_INSTR(ISSUE_INSTR),
    .ISSUE_OPND(ISSUE_OPND), .ISSUE_VL(ISSUE_VL),
    .ISSUE_SEW(ISSUE_SEW), .ISSUE_CREDIT(ISSUE_CREDIT),
    .COMPLETED_VALID(COMPLETED_VALID), .INFLIGHT(INFLIGHT),
    .IDLE(IDLE), .ERR(ERR)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset(input logic halt_v);
    RST_N = 1'b0; HALT = halt_v; REQ_VALID = 1'b0;
    REQ_INSTR = '0; REQ_OPND = '0; CFG_WE = 1'b0;
    CFG_VL = '0; CFG_SEW = '0;
    ISSUE_CREDIT = 1'b0; COMPLETED_VALID = 1'b0;
    tick();
    tick();
    RST_N = 1'b1;
  endtask

  task automatic push(input logic [31:0] ins);
    REQ_VALID = 1'b1;
    REQ_INSTR = ins;
    REQ_OPND  = {ins, ~ins};
  endtask

  initial begin
    // reset; first cycle out of reset with HALT=0
    do_reset(1'b0);
    RST_N = 1'b0;
    settle();
    chk("ready_in_reset", REQ_READY, 0);
    RST_N = 1'b1;
    push(32'hA0);
    settle();
    chk("rst_ready", REQ_READY, 1);
    chk("rst_valid", ISSUE_VALID, 0);
    chk("rst_inflight", INFLIGHT, 0);
    chk("rst_idle", IDLE, 1);
    chk("rst_err", ERR, 0);
    chk("rst_vl", ISSUE_VL, 8);
    chk("rst_sew", ISSUE_SEW, 2);
    tick();
    push(32'hB0);
    settle();
    chk("t1_v1", ISSUE_VALID, 1);
    chk("t1_i1", ISSUE_INSTR, 32'hA0);
    chk("t1_o1", ISSUE_OPND, {32'hA0, ~32'hA0});
    chk("t1_rdy", REQ_READY, 1);
    tick();
    push(32'hC0);
    settle();
    chk("t1_v2", ISSUE_VALID, 1);
    chk("t1_i2", ISSUE_INSTR, 32'hB0);
    tick();
    REQ_VALID = 1'b0;
    settle();
    chk("t1_v3", ISSUE_VALID, 1);
    chk("t1_i3", ISSUE_INSTR, 32'hC0);
    chk("t1_if2", INFLIGHT, 2);
    tick();
    // one credit left
    push(32'hD0);
    settle();
    chk("t1_v_empty", ISSUE_VALID, 0);
    chk("t1_if3", INFLIGHT, 3);
    tick();
    push(32'hE0);
    settle();
    chk("t2_v4", ISSUE_VALID, 1);
    chk("t2_i4", ISSUE_INSTR, 32'hD0);
    tick();
    REQ_VALID = 1'b0;
    ISSUE_CREDIT = 1'b1;
    settle();
    chk("t2_nocredit", ISSUE_VALID, 0);
    chk("t2_if4", INFLIGHT, 4);
    tick();
    ISSUE_CREDIT = 1'b0;
    settle();
    chk("t2_v5", ISSUE_VALID, 1);
    chk("t2_i5", ISSUE_INSTR, 32'hE0);
    tick();
    settle();
    chk("t2_v_after", ISSUE_VALID, 0);
    chk("t2_if5", INFLIGHT, 5);
    chk("t2_err", ERR, 0);

    // mid-operation reset, fill FIFO while halted
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) begin
      push(32'hF0 + 32'(i));
      settle();
      chk("t3_fill_rdy", REQ_READY, 1);
      chk("t3_fill_nv", ISSUE_VALID, 0);
      tick();
    end
    push(32'hF4);
    settle();
    chk("t3_full_rdy", REQ_READY, 0);
    chk("t3_full_nv", ISSUE_VALID, 0);
    chk("t3_idle", IDLE, 1);
    REQ_VALID = 1'b0;
    HALT = 1'b0;
    tick();
    CFG_WE = 1'b1; CFG_VL = 14'd16; CFG_SEW = 3'd3;
    settle();
    chk("t3_v0", ISSUE_VALID, 1);
    chk("t3_i0", ISSUE_INSTR, 32'hF0);
    chk("t3_rdy_full", REQ_READY, 0);
    chk("t5_old_vl", ISSUE_VL, 8);
    chk("t5_old_sew", ISSUE_SEW, 2);
    tick();
    CFG_WE = 1'b0;
    settle();
    chk("t3_v1", ISSUE_VALID, 1);
    chk("t3_i1", ISSUE_INSTR, 32'hF1);
    chk("t3_rdy_freed", REQ_READY, 1);
    chk("t5_new_vl", ISSUE_VL, 16);
    chk("t5_new_sew", ISSUE_SEW, 3);
    tick();
    settle();
    chk("t3_i2", ISSUE_INSTR, 32'hF2);
    chk("t3_v2", ISSUE_VALID, 1);
    tick();
    settle();
    chk("t3_i3", ISSUE_INSTR, 32'hF3);
    chk("t3_v3", ISSUE_VALID, 1);
    tick();
    push(32'h60);
    ISSUE_CREDIT = 1'b1;
    settle();
    chk("t3_empty", ISSUE_VALID, 0);
    chk("t3_if4", INFLIGHT, 4);
    tick();

    // halt with instr and credit ready, then drain
    REQ_VALID = 1'b0;
    ISSUE_CREDIT = 1'b0;
    HALT = 1'b1;
    COMPLETED_VALID = 1'b1;
    settle();
    chk("t4_halt_nv", ISSUE_VALID, 0);
    tick();
    settle();
    chk("t4_drain_idle", IDLE, 0);
    chk("t4_drain_nv", ISSUE_VALID, 0);
    chk("t4_if3", INFLIGHT, 3);
    tick();
    tick();
    settle();
    chk("t4_if1", INFLIGHT, 1);
    chk("t4_idle_last", IDLE, 0);
    tick();
    COMPLETED_VALID = 1'b0;
    settle();
    chk("t4_idle", IDLE, 1);
    chk("t4_if0", INFLIGHT, 0);
    chk("t4_err", ERR, 0);

    // completion underflow
    COMPLETED_VALID = 1'b1;
    tick();
    COMPLETED_VALID = 1'b0;
    settle();
    chk("t6_cerr", ERR, 1);
    chk("t6_if0", INFLIGHT, 0);
    tick();
    tick();
    settle();
    chk("t6_sticky", ERR, 1);
    do_reset(1'b1);
    settle();
    chk("t6_clr1", ERR, 0);

    // credit overflow, then check credits stayed at 4
    ISSUE_CREDIT = 1'b1;
    settle();
    chk("t6_pre", ERR, 0);
    tick();
    ISSUE_CREDIT = 1'b0;
    settle();
    chk("t6_crerr", ERR, 1);
    for (int i = 0; i < 5; i++) begin
      push(32'h70 + 32'(i));
      if (i == 0) HALT = 1'b0;
      tick();
    end
    REQ_VALID = 1'b0;
    tick();
    tick();
    settle();
    chk("t6_cr_if", INFLIGHT, 4);
    chk("t6_cr_nv", ISSUE_VALID, 0);
    chk("t6_cr_sticky", ERR, 1);
    do_reset(1'b0);
    settle();
    chk("t6_clr2", ERR, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
